// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read feeding a {pc, word} prefetch FIFO; redirect flushes and restarts.
// Ack at edge N shows on inst_* after edge N; imem_req drops while the FIFO is full, core backpressures via inst_ready.

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;

  // Flush wins over push/pop; storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_i && !pop_i) count_q <= count_q + CNT_ONE;
      else if (pop_i && !push_i) count_q <= count_q - CNT_ONE;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_ent_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_pc;
  logic [31:0] pc_inc;
  logic        push;
  logic        pop;
  fetch_ent_t  push_ent;
  fetch_ent_t  head_ent;
  logic [CNT_W-1:0] count;

  assign tgt_pc     = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc     = fetch_pc_q + 32'd4;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect;
  assign push_ent   = '{pc: addr_q, word: imem_rdata};

  // addr_q is the address on the bus; it only diverges from fetch_pc_q while a dropped request is in flight.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = tgt_pc;
          addr_d     = tgt_pc;
          state_d    = S_WAIT;
        end else if (count < FULL) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = tgt_pc;
          if (imem_ack) addr_d = tgt_pc;
          else          state_d = S_DISCARD;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_inc;
          addr_d     = pc_inc;
          if (!pop && count == LAST_FREE) state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (redirect) fetch_pc_d = tgt_pc;
        if (imem_ack) begin
          state_d = S_WAIT;
          addr_d  = fetch_pc_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_pf_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_dat_o (head_ent),
    .count_o    (count)
  );

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;
  assign inst      = head_ent.word;
  assign inst_pc   = head_ent.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory model, scoreboard of expected {pc, word} consumed at inst handshakes.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   wait_cycles  = 0;
  int   wcnt         = 0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
  endfunction

  // Memory: acks after wait_cycles idle cycles of a held request, data valid with the ack.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end else if (wcnt >= wait_cycles) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Scoreboard consumer: every accepted instruction must match the next expected entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1 &&
          redirect === 1'b0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (inst_pc !== e.pc || inst !== e.word) begin
          tests_failed++;
          $display("FAIL scoreboard: got pc=%h inst=%h, expected pc=%h inst=%h",
                   inst_pc, inst, e.pc, e.word);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int wc, input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = rdy;
    wait_cycles = wc;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d expected words never delivered, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1; wait_cycles = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b required 0", imem_req); end
    tests_run++;
    if (imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL reset_addr: got %h required %h", imem_addr, RESET_PC); end
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", inst_valid); end
    tests_run++;
    if (inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h required 0", inst); end
    tests_run++;
    if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_pc: got %h required 0", inst_pc); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL req_before_edge: got %b required 0", imem_req); end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL first_req: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset(0, 1'b1);
    for (int k = 0; k < 12; k++) push_exp(32'(4 * k));
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
        tests_failed++;
        $display("FAIL stream_addr: edge %0d got req=%b addr=%h required req=1 addr=%h",
                 k, imem_req, imem_addr, 32'(4 * (k - 1)));
      end
      if (k <= 2) begin
        tests_run++;
        if (inst_valid !== (k == 2)) begin
          tests_failed++;
          $display("FAIL first_valid: edge %0d got %b required %b", k, inst_valid, (k == 2));
        end
      end
    end
    drain("stream_drain", 40);
  endtask

  task automatic test_wait3();
    do_reset(3, 1'b1);
    for (int w = 0; w < 6; w++) push_exp(32'(4 * w));
    for (int w = 0; w < 6; w++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * w)) begin
          tests_failed++;
          $display("FAIL wait3_addr: word %0d cycle %0d got req=%b addr=%h required req=1 addr=%h",
                   w, c, imem_req, imem_addr, 32'(4 * w));
        end
        tests_run++;
        if (inst_valid !== (c == 0 && w > 0)) begin
          tests_failed++;
          $display("FAIL wait3_valid: word %0d cycle %0d got %b required %b",
                   w, c, inst_valid, (c == 0 && w > 0));
        end
      end
    end
    drain("wait3_drain", 40);
  endtask

  task automatic test_full();
    do_reset(0, 1'b0);
    for (int k = 0; k < 6; k++) push_exp(32'(4 * k));
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL full_no_req: got %b required 0", imem_req); end
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL full_head: got valid=%b pc=%h required valid=1 pc=0", inst_valid, inst_pc);
    end
    @(posedge clk);
    #1 inst_ready = 1'b1;
    for (int i = 0; i < 6 && imem_req !== 1'b1; i++) @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      tests_failed++;
      $display("FAIL resume_addr: got req=%b addr=%h required req=1 addr=00000010", imem_req, imem_addr);
    end
    drain("full_drain", 30);
  endtask

  task automatic test_redirect_pending();
    bit found = 1'b0;
    do_reset(2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === 32'h8) begin found = 1'b1; break; end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL rdp_reach: request to 00000008 not seen, required within 20 cycles"); end
    tests_run++;
    if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL rdp_prefill: got valid=%b required 1", inst_valid); end
    @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rdp_flush: got valid=%b required 0", inst_valid); end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      tests_failed++;
      $display("FAIL rdp_hold: got req=%b addr=%h required req=1 addr=00000008", imem_req, imem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL rdp_new_addr: got req=%b addr=%h required req=1 addr=00000100", imem_req, imem_addr);
    end
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rdp_drop: got valid=%b required 0", inst_valid); end
    exp_q.delete();
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    @(posedge clk);
    #1 inst_ready = 1'b1;
    drain("rdp_drain", 40);
  endtask

  task automatic test_back_to_back();
    bit found = 1'b0;
    do_reset(0, 1'b1);
    for (int k = 0; k < 4; k++) push_exp(32'(4 * k));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1 && inst_pc === 32'hC) begin found = 1'b1; break; end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL rda_reach: head pc 0000000c not seen, required within 20 cycles"); end
    @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_2000;
    exp_q.delete();
    push_exp(32'h2000); push_exp(32'h2004); push_exp(32'h2008);
    @(negedge clk);
    tests_run++;
    if (imem_ack !== 1'b1 || inst_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rda_precond: got ack=%b valid=%b required ack=1 valid=1", imem_ack, inst_valid);
    end
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rda_no_push: got valid=%b required 0", inst_valid); end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      tests_failed++;
      $display("FAIL rda_new_addr: got req=%b addr=%h required req=1 addr=00002000", imem_req, imem_addr);
    end
    drain("rda_drain", 20);
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset(0, 1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_addr !== 32'hFFFF_FFF8) begin
      tests_failed++;
      $display("FAIL wrap_first_addr: got %h required fffffff8", imem_addr);
    end
    drain("wrap_drain", 20);
    @(posedge clk);
    #1 inst_ready = 1'b0; wait_cycles = 3;
    repeat (6) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: got req=%b valid=%b required req=1 valid=1", imem_req, inst_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL async_reset_req: got %b required 0", imem_req); end
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL async_reset_valid: got %b required 0", inst_valid); end
    tests_run++;
    if (imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL async_reset_addr: got %h required %h", imem_addr, RESET_PC); end
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    test_reset();
    test_stream();
    test_wait3();
    test_full();
    test_redirect_pending();
    test_back_to_back();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
